// File: rtl/icache_refill_pkg.sv
// Shared I-cache definitions: refill FSM encoding and line-offset geometry.
// The I-cache and the refill engine both import this so they agree on line alignment.
package icache_refill_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_RESP = 2'd3
    } refill_state_e;

    // Byte-offset bits inside one cache line.
    function automatic int line_offset_bits(input int block_width);
        return $clog2(block_width / 8);
    endfunction

    localparam int LINE_OFFSET_BITS = line_offset_bits(256);

endpackage

// File: rtl/icache_refill.sv
// I-cache line refill engine: one memory read request per miss, beats assembled
// into a registered line buffer, single-cycle resp_ready when the line is complete.
//
//   state   | meaning
//   IDLE    | waiting for a miss; req_valid latches the line-aligned address
//   REQ     | mem_req_valid held with the latched address until mem_req_ready
//   FILL    | one beat written per mem_rsp_valid cycle, ascending order
//   RESP    | resp_ready pulse, refill_count bumped, back to IDLE
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int BLOCK_WIDTH = 256,
    parameter int BUS_WIDTH   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [ADDR_W-1:0]      req_addr,
    output logic                   resp_ready,
    output logic [BLOCK_WIDTH-1:0] resp_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_W-1:0]      mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic [BUS_WIDTH-1:0]   mem_rsp_data,
    output logic                   busy,
    output logic [31:0]            refill_count
);

    localparam int BEATS    = BLOCK_WIDTH / BUS_WIDTH;
    localparam int BEAT_W   = $clog2(BEATS);
    localparam int OFF_BITS = line_offset_bits(BLOCK_WIDTH);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_BITS) - ADDR_W'(1));
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    refill_state_e          state_q, state_d;
    logic [BEAT_W-1:0]      beat_q,  beat_d;
    logic [ADDR_W-1:0]      addr_q,  addr_d;
    logic [BLOCK_WIDTH-1:0] line_q,  line_d;
    logic [31:0]            count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        line_d  = line_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr & LINE_MASK;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    beat_d  = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_rsp_valid) begin
                    line_d[int'(beat_q) * BUS_WIDTH +: BUS_WIDTH] = mem_rsp_data;
                    // Counter wraps to zero on the last beat by construction.
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (count_q != 32'hFFFF_FFFF) begin
                    count_d = count_q + 32'd1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        resp_ready    = (state_q == ST_RESP);
        mem_req_valid = (state_q == ST_REQ);
        busy          = (state_q != ST_IDLE);
        resp_data     = line_q;
        mem_req_addr  = addr_q;
        refill_count  = count_q;
    end

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: scoreboard of expected requests/lines
// checked by a monitor, plus per-scenario inline checks.
module tb_icache_refill;

    localparam int BW = 256;
    localparam int UW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [31:0]   req_addr;
    logic          resp_ready;
    logic [BW-1:0] resp_data;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [31:0]   mem_req_addr;
    logic          mem_rsp_valid;
    logic [UW-1:0] mem_rsp_data;
    logic          busy;
    logic [31:0]   refill_count;

    icache_refill #(.BLOCK_WIDTH(BW), .BUS_WIDTH(UW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .busy          (busy),
        .refill_count  (refill_count)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            n_req = 0;
    int            exp_req = 0;
    logic [31:0]   exp_count = '0;
    logic [31:0]   exp_addr_q[$];
    logic [BW-1:0] exp_line_q[$];
    logic [31:0]   mon_addr;
    logic [BW-1:0] mon_line;
    logic          prev_resp = 1'b0;

    // Monitor: samples just after the input-drive edge; outputs are registered.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (mem_req_valid && mem_req_ready) begin
                n_req++;
                n_vec++;
                if (exp_addr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL mem_req_unexpected addr=%h", mem_req_addr);
                end else begin
                    mon_addr = exp_addr_q.pop_front();
                    if (mem_req_addr !== mon_addr) begin
                        n_err++;
                        $display("FAIL mem_req_addr got=%h exp=%h", mem_req_addr, mon_addr);
                    end
                end
            end
            if (resp_ready) begin
                n_vec++;
                if (exp_line_q.size() == 0) begin
                    n_err++;
                    $display("FAIL resp_unexpected data=%h", resp_data);
                end else begin
                    mon_line = exp_line_q.pop_front();
                    if (resp_data !== mon_line) begin
                        n_err++;
                        $display("FAIL resp_data got=%h exp=%h", resp_data, mon_line);
                    end
                end
                if (prev_resp) begin
                    n_err++;
                    $display("FAIL resp_ready_width got=2+ cycles exp=1");
                end
            end
        end
        prev_resp = resp_ready && !rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Full refill starting at a negedge in IDLE; ends at the negedge after RESP.
    task automatic run_refill(input logic [31:0] addr, input logic [63:0] base,
                              input int req_wait, input int g1, input int g2,
                              input int g3, output int lat);
        logic [BW-1:0] line;
        int gaps[4];
        int t;
        gaps = '{0, g1, g2, g3};
        for (int k = 0; k < 4; k++) line[k*UW +: UW] = base + 64'(k);
        exp_addr_q.push_back(addr & 32'hFFFF_FFE0);
        exp_line_q.push_back(line);
        exp_req++;
        req_valid = 1'b1;
        req_addr  = addr;
        t = 0;
        @(negedge clk); t++;
        req_valid     = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = ~base;
        for (int i = 0; i < req_wait; i++) begin
            mem_req_ready = 1'b0;
            n_vec++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== (addr & 32'hFFFF_FFE0)) begin
                n_err++;
                $display("FAIL req_stall cyc=%0d got valid=%b addr=%h exp valid=1 addr=%h",
                         i, mem_req_valid, mem_req_addr, addr & 32'hFFFF_FFE0);
            end
            @(negedge clk); t++;
        end
        mem_req_ready = 1'b1;
        @(negedge clk); t++;
        mem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = ~base;
                @(negedge clk); t++;
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = base + 64'(k);
            @(negedge clk); t++;
        end
        mem_rsp_valid = 1'b0;
        lat = t;
        n_vec++;
        if (resp_ready !== 1'b1) begin
            n_err++;
            $display("FAIL resp_pulse got=%b exp=1", resp_ready);
        end
        if (exp_count != 32'hFFFF_FFFF) exp_count++;
        @(negedge clk);
        n_vec++;
        if (resp_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL after_resp got resp_ready=%b busy=%b exp 0 0", resp_ready, busy);
        end
        n_vec++;
        if (refill_count !== exp_count) begin
            n_err++;
            $display("FAIL refill_count got=%h exp=%h", refill_count, exp_count);
        end
        n_vec++;
        if (resp_data !== line) begin
            n_err++;
            $display("FAIL resp_data_hold got=%h exp=%h", resp_data, line);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if (resp_ready !== 1'b0 || mem_req_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_ctrl got resp=%b mreq=%b busy=%b exp 0 0 0",
                     tag, resp_ready, mem_req_valid, busy);
        end
        n_vec++;
        if (resp_data !== '0) begin
            n_err++;
            $display("FAIL %s_data got=%h exp=0", tag, resp_data);
        end
        n_vec++;
        if (mem_req_addr !== 32'h0 || refill_count !== 32'h0) begin
            n_err++;
            $display("FAIL %s_regs got addr=%h count=%h exp 0 0", tag, mem_req_addr, refill_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        exp_count = '0;
        @(negedge clk);
        check_reset_outputs("post_reset");
    endtask

    task automatic test_basic();
        int lat;
        run_refill(32'h0000_1234, 64'hA0, 0, 0, 0, 0, lat);
        n_vec++;
        if (lat != 6) begin
            n_err++;
            $display("FAIL basic_latency got=%0d exp=6", lat);
        end
    endtask

    task automatic test_req_stall();
        int lat;
        run_refill(32'hFFFF_FFFF, 64'h1111_2222_3333_4440, 5, 0, 0, 0, lat);
    endtask

    task automatic test_beat_gaps();
        int lat;
        logic [BW-1:0] line_now;
        run_refill(32'h0012_3460, 64'h5A5A_0000_0000_0010, 0, 0, 3, 1, lat);
        line_now = {64'h5A5A_0000_0000_0013, 64'h5A5A_0000_0000_0012,
                    64'h5A5A_0000_0000_0011, 64'h5A5A_0000_0000_0010};
        mem_rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_rsp_data = 64'hBAD0 + 64'(i);
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0;
        n_vec++;
        if (resp_data !== line_now || refill_count !== exp_count || busy !== 1'b0) begin
            n_err++;
            $display("FAIL stray_beat got data=%h count=%h busy=%b exp data=%h count=%h busy=0",
                     resp_data, refill_count, busy, line_now, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d [15];
        logic [BW-1:0] l1, l2;
        logic exp_rr;
        for (int j = 0; j < 15; j++) d[j] = 64'hB000 + 64'(j);
        l1 = {d[5], d[4], d[3], d[2]};
        l2 = {d[12], d[11], d[10], d[9]};
        exp_addr_q.push_back(32'h4000_0040);
        exp_addr_q.push_back(32'h4000_0040);
        exp_line_q.push_back(l1);
        exp_line_q.push_back(l2);
        exp_req += 2;
        for (int j = 0; j < 15; j++) begin
            req_valid     = (j != 3) && (j < 14);
            req_addr      = 32'h4000_0047;
            mem_req_ready = 1'b1;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = d[j];
            exp_rr = (j == 6) || (j == 13);
            n_vec++;
            if (resp_ready !== exp_rr) begin
                n_err++;
                $display("FAIL b2b_resp cyc=%0d got=%b exp=%b", j, resp_ready, exp_rr);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        exp_count += 2;
        n_vec++;
        if (refill_count !== exp_count || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_count got=%h busy=%b exp=%h busy=0", refill_count, busy, exp_count);
        end
    endtask

    task automatic test_reset_midfill();
        int lat;
        exp_addr_q.push_back(32'h0000_8A40);
        exp_req++;
        req_valid = 1'b1;
        req_addr  = 32'h0000_8A5C;
        @(negedge clk);
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hC0;
        @(negedge clk);
        mem_rsp_data  = 64'hC1;
        @(negedge clk);
        rst = 1'b1;
        mem_rsp_data = 64'hC2;
        @(negedge clk);
        check_reset_outputs("midfill_rst");
        rst = 1'b0;
        exp_count = '0;
        mem_rsp_data = 64'hC3;
        @(negedge clk);
        mem_rsp_data = 64'hC4;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check_reset_outputs("after_rst_beats");
        run_refill(32'h0000_8A5C, 64'hD0, 0, 1, 0, 0, lat);
    endtask

    task automatic test_saturation();
        int lat;
        force dut.count_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.count_q;
        exp_count = 32'hFFFF_FFFE;
        @(negedge clk);
        n_vec++;
        if (refill_count !== exp_count) begin
            n_err++;
            $display("FAIL sat_preload got=%h exp=%h", refill_count, exp_count);
        end
        for (int i = 0; i < 3; i++) begin
            run_refill(32'h0000_0100 + 32'(i * 32), 64'hE0 + 64'(i * 16), 0, 0, 0, 0, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_req_stall();
        test_beat_gaps();
        test_back_to_back();
        test_reset_midfill();
        test_saturation();
        repeat (2) @(negedge clk);
        n_vec++;
        if (exp_addr_q.size() != 0 || exp_line_q.size() != 0 || n_req != exp_req) begin
            n_err++;
            $display("FAIL scoreboard_drain got addr_left=%0d line_left=%0d reqs=%0d exp 0 0 %0d",
                     exp_addr_q.size(), exp_line_q.size(), n_req, exp_req);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
